// File: rtl/fsm_stream_sequencer_if.sv
// ============================================================================
// Module  : fsm_stream_sequencer_if
// Brief   : Config/status bundle between a test master and the sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsm_stream_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int LW    = 5
);
  logic             start;
  logic             clear_first;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    len;
  logic             busy;
  logic             done;
  logic [LW-1:0]    match_count;

  modport master (
    output start, clear_first, pattern, len,
    input  busy, done, match_count
  );

  modport slave (
    input  start, clear_first, pattern, len,
    output busy, done, match_count
  );
endinterface

`default_nettype wire

// File: rtl/fsm_stream_sequencer.sv
// ============================================================================
// Module  : fsm_stream_sequencer
// Brief   : Shifts a latched bit pattern MSB-first into a 1-bit-input FSM and
//           counts the cycles on which the FSM state equals TARGET.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_stream_sequencer #(
  parameter int         WIDTH      = 16,
  parameter int         LW         = 5,
  parameter logic [2:0] TARGET     = 3'b101,
  parameter int         CLR_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         n_reset,
  fsm_stream_sequencer_if.slave        cfg,
  input  logic [2:0]                   i_fsm_q,
  output logic                         o_fsm_in,
  output logic                         o_fsm_n_reset
);

  localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_CNT_W = $clog2(CLR_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_pattern;
  logic [LW-1:0]        r_len;
  logic [c_IDX_W-1:0]   r_idx;
  logic [LW-1:0]        r_match_count;
  logic [c_CNT_W-1:0]   r_clr_cnt;
  logic                 r_clr_n;
  logic                 r_first;

  logic                 w_accept;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_fsm_in;
  logic                 w_sample;
  logic [LW-1:0]        w_len_clamped;
  logic [c_IDX_W-1:0]   w_idx_init;

  assign w_len_clamped = (cfg.len > LW'(WIDTH)) ? LW'(WIDTH) : cfg.len;
  assign w_idx_init    = c_IDX_W'(w_len_clamped - LW'(1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_fsm_in     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg.start) begin
          w_accept = 1'b1;
          if (cfg.clear_first)
            w_state_next = S_CLEAR;
          else if (w_len_clamped == '0)
            w_state_next = S_DRAIN;
          else
            w_state_next = S_SHIFT;
        end
      end
      S_CLEAR: begin
        w_busy = 1'b1;
        if (r_clr_cnt == c_CNT_W'(CLR_CYCLES - 1))
          w_state_next = (r_len == '0) ? S_DRAIN : S_SHIFT;
      end
      S_SHIFT: begin
        w_busy   = 1'b1;
        w_fsm_in = r_pattern[r_idx];
        if (r_idx == '0)
          w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy       = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The FSM reacts to a shifted bit one edge later, so the first SHIFT cycle
  // has nothing new to observe and DRAIN sees the response to the last bit.
  assign w_sample = ((r_state == S_SHIFT) && !r_first) ||
                    ((r_state == S_DRAIN) && (r_len != '0));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pattern     <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_match_count <= '0;
      r_clr_cnt     <= '0;
      r_clr_n       <= 1'b1;
      r_first       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pattern     <= cfg.pattern;
        r_len         <= w_len_clamped;
        r_idx         <= w_idx_init;
        r_match_count <= '0;
      end else begin
        if ((r_state == S_SHIFT) && (r_idx != '0))
          r_idx <= r_idx - c_IDX_W'(1);
        if (w_sample && (i_fsm_q == TARGET))
          r_match_count <= r_match_count + LW'(1);
      end
      r_clr_cnt <= (r_state == S_CLEAR) ? (r_clr_cnt + c_CNT_W'(1)) : '0;
      r_clr_n   <= (w_state_next != S_CLEAR);
      r_first   <= (w_state_next == S_SHIFT) && (r_state != S_SHIFT);
    end
  end

  assign o_fsm_in        = w_fsm_in;
  assign o_fsm_n_reset   = n_reset & r_clr_n;
  assign cfg.busy        = w_busy;
  assign cfg.done        = w_done;
  assign cfg.match_count = r_match_count;

endmodule

`default_nettype wire

// File: doc/fsm_stream_sequencer.md
Name: fsm_stream_sequencer

Overview:
Controller that sequences a 1-bit-input state machine (3-bit state output, active-low async reset, e.g. fsm001) through a programmed serial bit pattern. It optionally clears the FSM, then shifts the pattern into the FSM's `in` one bit per clock, MSB-first. After each bit it samples the FSM's `Q` and counts the cycles where `Q` equals a target code. It sits between a test/config master and the FSM, and owns the FSM's `in` and `n_reset` pins.

Parameters:
- WIDTH, 16, maximum pattern length in bits.
- LW, 5, width of `len` and `match_count`; must be ≥ clog2(WIDTH+1).
- TARGET, 3'b101, `Q` code that is counted as a match.
- CLR_CYCLES, 2, number of cycles `fsm_n_reset` is held low in the CLEAR state (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE.
- clear_first  input  1  sampled with `start`; 1 = clear the FSM before shifting.
- pattern  input  WIDTH  bit pattern; latched on accepted `start`.
- len  input  LW  number of bits to shift; latched on accepted `start`.
- fsm_q  input  3  FSM state output `Q`.
- fsm_in  output  1  drives FSM `in`.
- fsm_n_reset  output  1  drives FSM `n_reset`.
- busy  output  1  run in progress.
- done  output  1  one-cycle completion pulse.
- match_count  output  LW  number of samples with `fsm_q == TARGET` in the last run.

Behaviour:
- Reset value of every output while `n_reset` = 0:
  - `fsm_in` = 0, `busy` = 0, `done` = 0, `match_count` = 0.
  - `fsm_n_reset` = 0 (combinational AND of `n_reset` with an internal clear register that resets to 1). The FSM is therefore reset together with the sequencer.
  - State = IDLE.
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - `busy` = 0, `fsm_in` = 0.
  - On `start` = 1: latch `pattern`, and latch `len` clamped to WIDTH; clear `match_count` to 0; set bit index = len−1.
  - Next state is CLEAR if `clear_first` = 1, else SHIFT; if len = 0 and `clear_first` = 0, next state is DRAIN.
- CLEAR:
  - `fsm_n_reset` = 0 for exactly CLR_CYCLES cycles, `fsm_in` = 0.
  - Then go to SHIFT, or to DRAIN if len = 0.
- SHIFT:
  - Each cycle drive `fsm_in` = pattern[idx], then decrement idx.
  - Stay for exactly len cycles, then go to DRAIN.
- Sampling:
  - `fsm_q` is sampled in every SHIFT cycle except the first, and in the DRAIN cycle. This gives exactly len samples, each reflecting the FSM state after one shifted bit.
  - When the sample equals TARGET, increment `match_count`. No saturation is needed, since count ≤ WIDTH.
  - With len = 0 there are no samples: DRAIN does not sample, and `match_count` stays 0.
- DRAIN:
  - `fsm_in` = 0.
  - One cycle, then go to DONE.
- DONE:
  - `done` = 1 and `busy` = 0 for one cycle, then return to IDLE.
- `busy` = 1 in CLEAR, SHIFT and DRAIN.
- Latency from the `start` sampling edge to the `done` cycle: len + 2 cycles without clear, len + 2 + CLR_CYCLES cycles with clear.
- `match_count` holds its value from DONE until the next accepted `start`.
- Boundary conditions:
  - `start` while not in IDLE (including the DONE cycle): ignored.
  - Changes to `pattern`/`len` during a run: no effect.
  - `start` held high continuously: a new run begins on each IDLE cycle, i.e. back-to-back runs separated by one IDLE cycle.
  - `n_reset` asserted mid-run: immediate abort to the reset values, with `fsm_n_reset` low. After release the block sits in IDLE and `done` is never pulsed for the aborted run.

Test Plan:
All scenarios use a bench FSM stub: `Q` = last 3 input bits shifted in, reset value 3'b000, TARGET = 3'b101.
1. Reset, then start with pattern = 5'b10101, len = 5, clear_first = 0 → `Q` sequence 001, 010, 101, 010, 101; `match_count` = 2; `done` pulses exactly 7 cycles after the start edge; `busy` high for cycles 1–6.
2. Preload the stub with 3'b111, then start with clear_first = 1, pattern = 3'b101, len = 3 → `fsm_n_reset` low for 2 cycles; samples 001, 010, 101; `match_count` = 1; `done` at cycle 7.
3. len = 0, clear_first = 0 → `done` pulses 2 cycles after start; `match_count` = 0; `fsm_in` stays 0.
4. len = 31 with WIDTH = 16, pattern = 16'hAAAA → clamped to 16 shifts; `fsm_in` equals 1,0,1,0…; `match_count` = 7; `done` at cycle 18.
5. Pulse `start` during SHIFT with a different pattern, and keep `start` high through DONE → the first run is unaffected; the next run starts only from IDLE, one cycle after `done`.
6. Assert `n_reset` low for 2 cycles in the middle of SHIFT → `fsm_n_reset` = 0 at once; `busy` = 0, `match_count` = 0, no `done` pulse; a subsequent clean run of scenario 1 gives `match_count` = 2.
